// File: rtl/isplit_stream.sv
// Streaming Y86 instruction splitter: buffers fetch beats as bytes and presents
// one fully decoded instruction at the buffer head per handshake.
module isplit_stream #(
  parameter int IN_BYTES  = 4,
  parameter int WORD_W    = 32,
  parameter int BUF_BYTES = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [8*IN_BYTES-1:0]          in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [3:0]                     icode,
  output logic [3:0]                     ifun,
  output logic [3:0]                     rA,
  output logic [3:0]                     rB,
  output logic [WORD_W-1:0]              Dest,
  output logic [WORD_W-1:0]              D_V,
  output logic [3:0]                     ilen,
  output logic                           ierr,
  output logic [$clog2(BUF_BYTES+1)-1:0] level
);

  localparam int IMM_BYTES = WORD_W / 8;
  localparam int LW        = $clog2(BUF_BYTES + 1);
  localparam int BUF_W     = 8 * BUF_BYTES;
  localparam int IN_W      = 8 * IN_BYTES;
  localparam logic [LW-1:0] BUF_L = LW'(BUF_BYTES);
  localparam logic [LW-1:0] IN_L  = LW'(IN_BYTES);

  logic [BUF_W-1:0] mem_q;
  logic [BUF_W-1:0] mem_d;
  logic [BUF_W-1:0] popped;
  logic [BUF_W-1:0] push_data;
  logic [BUF_W-1:0] push_mask;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    pop_n;
  logic [LW-1:0]    base;
  logic [3:0]       head_icode;
  logic [3:0]       head_len;
  logic             head_err;
  logic             head_ok;
  logic             push;
  logic             pop;

  assign head_icode = mem_q[7:4];

  always_comb begin
    head_len = 4'd1;
    head_err = 1'b0;
    case (head_icode)
      4'h0, 4'h1, 4'h9:        head_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:  head_len = 4'd2;
      4'h7, 4'h8:              head_len = 4'(1 + IMM_BYTES);
      4'h3, 4'h4, 4'h5:        head_len = 4'(2 + IMM_BYTES);
      default: begin
        head_len = 4'd1;
        head_err = 1'b1;
      end
    endcase
  end

  assign head_ok   = (level_q != '0) && (level_q >= LW'(head_len));
  assign out_valid = !reset && head_ok;
  assign in_ready  = !reset && ((BUF_L - level_q) >= IN_L);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign pop_n     = pop ? LW'(head_len) : '0;
  assign base      = level_q - pop_n;

  // Pop shifts the head out first; the beat then lands right behind what remains.
  always_comb begin
    popped    = mem_q >> {pop_n, 3'b000};
    push_data = {{(BUF_W - IN_W){1'b0}}, in_data} << {base, 3'b000};
    push_mask = {{(BUF_W - IN_W){1'b0}}, {IN_W{1'b1}}} << {base, 3'b000};
    mem_d     = push ? ((popped & ~push_mask) | push_data) : popped;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      level_q <= '0;
    end else begin
      level_q <= level_q + (push ? IN_L : '0) - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    icode = '0;
    ifun  = '0;
    rA    = '0;
    rB    = '0;
    Dest  = '0;
    D_V   = '0;
    ilen  = '0;
    ierr  = 1'b0;
    if (out_valid) begin
      icode = mem_q[7:4];
      ifun  = mem_q[3:0];
      rA    = mem_q[15:12];
      rB    = mem_q[11:8];
      Dest  = mem_q[8 +: WORD_W];
      D_V   = mem_q[16 +: WORD_W];
      ilen  = head_len;
      ierr  = head_err;
    end
  end

  assign level = level_q;

endmodule

// File: tb/tb_isplit_stream.sv
// Directed bench for isplit_stream: a vector table of single-cycle steps plus
// hand-written flush/reset and straddling-instruction sequences.
module tb_isplit_stream;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [31:0] Dest;
  logic [31:0] D_V;
  logic [3:0]  ilen;
  logic        ierr;
  logic [4:0]  level;

  int checks;
  int failures;

  typedef struct {
    bit          rst, fl, iv;
    logic [31:0] data;
    bit          ordy;
    bit          ov, ir;
    int          lvl, ic, ifn, ra, rb, il;
    bit          ierr, creg, cimm;
    logic [31:0] dv, dest;
  } vec_t;

  vec_t vecs[$];

  isplit_stream #(.IN_BYTES(4), .WORD_W(32), .BUF_BYTES(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .Dest(Dest), .D_V(D_V), .ilen(ilen), .ierr(ierr), .level(level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input bit rst, input bit fl, input bit iv,
                               input logic [31:0] data, input bit ordy);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = data;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input bit ov, input bit ir, input int lvl,
                             input int ic, input int ifn, input int ra, input int rb,
                             input int il, input bit ie, input bit creg, input bit cimm,
                             input logic [31:0] dv, input logic [31:0] dest);
    cmp({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    cmp({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
    cmp({tag, ".level"}, 32'(level), 32'(lvl));
    cmp({tag, ".icode"}, 32'(icode), 32'(ic));
    cmp({tag, ".ifun"}, 32'(ifun), 32'(ifn));
    cmp({tag, ".ilen"}, 32'(ilen), 32'(il));
    cmp({tag, ".ierr"}, 32'(ierr), 32'(ie));
    if (creg) begin
      cmp({tag, ".rA"}, 32'(rA), 32'(ra));
      cmp({tag, ".rB"}, 32'(rB), 32'(rb));
    end
    if (cimm) begin
      cmp({tag, ".D_V"}, D_V, dv);
      cmp({tag, ".Dest"}, Dest, dest);
    end
  endtask

  task automatic addVec(input bit rst, input bit fl, input bit iv, input logic [31:0] data,
                        input bit ordy, input bit ov, input bit ir, input int lvl,
                        input int ic, input int ifn, input int ra, input int rb, input int il,
                        input bit ie, input bit creg, input bit cimm,
                        input logic [31:0] dv, input logic [31:0] dest);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.data = data; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.lvl = lvl; v.ic = ic; v.ifn = ifn; v.ra = ra; v.rb = rb;
    v.il = il; v.ierr = ie; v.creg = creg; v.cimm = cimm; v.dv = dv; v.dest = dest;
    vecs.push_back(v);
  endtask

  // Leaves the head as 30 F4 11 22 33 with level=5 (irmovl still one byte short).
  task automatic buildMidIrmovl(input string tag);
    applyStimulus(0, 0, 1, 32'h30000000, 0);
    applyStimulus(0, 0, 1, 32'h332211F4, 0);
    applyStimulus(0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput(tag, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //     rst fl iv data          ordy ov ir lvl ic   ifn ra   rb  il ie cr ci dv            dest
    addVec(1, 0, 0, 32'h0,         0,   0, 0, 0,  0,   0,  0,   0,  0, 0, 1, 1, 32'h0,        32'h0);
    addVec(1, 0, 0, 32'h0,         0,   0, 0, 0,  0,   0,  0,   0,  0, 0, 1, 1, 32'h0,        32'h0);
    addVec(0, 0, 0, 32'h0,         0,   0, 1, 0,  0,   0,  0,   0,  0, 0, 1, 1, 32'h0,        32'h0);
    addVec(0, 0, 1, 32'h5678F330,  0,   0, 1, 4,  0,   0,  0,   0,  0, 0, 1, 1, 32'h0,        32'h0);
    addVec(0, 0, 1, 32'h00101234,  0,   1, 1, 8,  3,   0,  15,  3,  6, 0, 1, 1, 32'h12345678, 32'h345678F3);
    addVec(0, 0, 0, 32'h0,         1,   1, 1, 2,  1,   0,  0,   0,  1, 0, 1, 0, 32'h0,        32'h0);
    addVec(0, 0, 0, 32'h0,         0,   1, 1, 2,  1,   0,  0,   0,  1, 0, 1, 0, 32'h0,        32'h0);
    addVec(0, 0, 0, 32'h0,         1,   1, 1, 1,  0,   0,  0,   0,  1, 0, 0, 0, 32'h0,        32'h0);
    addVec(0, 0, 0, 32'h0,         1,   0, 1, 0,  0,   0,  0,   0,  0, 0, 1, 1, 32'h0,        32'h0);
    addVec(0, 0, 1, 32'h10101010,  0,   1, 1, 4,  1,   0,  1,   0,  1, 0, 1, 0, 32'h0,        32'h0);
    addVec(0, 0, 1, 32'h10101010,  0,   1, 1, 8,  1,   0,  1,   0,  1, 0, 1, 1, 32'h10101010, 32'h10101010);
    addVec(0, 0, 1, 32'h10101010,  0,   1, 1, 12, 1,   0,  1,   0,  1, 0, 1, 1, 32'h10101010, 32'h10101010);
    addVec(0, 0, 1, 32'h10101010,  0,   1, 0, 16, 1,   0,  1,   0,  1, 0, 1, 1, 32'h10101010, 32'h10101010);
    addVec(0, 0, 1, 32'hFFFFFFFF,  0,   1, 0, 16, 1,   0,  1,   0,  1, 0, 1, 1, 32'h10101010, 32'h10101010);
    addVec(0, 0, 1, 32'hFFFFFFFF,  1,   1, 0, 15, 1,   0,  1,   0,  1, 0, 1, 1, 32'h10101010, 32'h10101010);
    addVec(0, 0, 0, 32'h0,         0,   1, 0, 15, 1,   0,  1,   0,  1, 0, 1, 1, 32'h10101010, 32'h10101010);
    addVec(0, 1, 0, 32'h0,         0,   0, 1, 0,  0,   0,  0,   0,  0, 0, 1, 1, 32'h0,        32'h0);
    addVec(0, 0, 1, 32'h10101260,  0,   1, 1, 4,  6,   0,  1,   2,  2, 0, 1, 0, 32'h0,        32'h0);
    addVec(0, 0, 1, 32'h00004520,  1,   1, 1, 6,  1,   0,  1,   0,  1, 0, 1, 1, 32'h00004520, 32'h00452010);
    addVec(0, 0, 0, 32'h0,         1,   1, 1, 5,  1,   0,  2,   0,  1, 0, 1, 0, 32'h0,        32'h0);
    addVec(0, 0, 0, 32'h0,         1,   1, 1, 4,  2,   0,  4,   5,  2, 0, 1, 0, 32'h0,        32'h0);
    addVec(0, 0, 0, 32'h0,         1,   1, 1, 2,  0,   0,  0,   0,  1, 0, 1, 0, 32'h0,        32'h0);
    addVec(0, 0, 0, 32'h0,         1,   1, 1, 1,  0,   0,  0,   0,  1, 0, 0, 0, 32'h0,        32'h0);
    addVec(0, 0, 0, 32'h0,         1,   0, 1, 0,  0,   0,  0,   0,  0, 0, 1, 1, 32'h0,        32'h0);
    addVec(0, 0, 1, 32'h000010C0,  0,   1, 1, 4,  12,  0,  1,   0,  1, 1, 1, 0, 32'h0,        32'h0);
    addVec(0, 0, 0, 32'h0,         1,   1, 1, 3,  1,   0,  0,   0,  1, 0, 1, 0, 32'h0,        32'h0);
    addVec(0, 1, 0, 32'h0,         0,   0, 1, 0,  0,   0,  0,   0,  0, 0, 1, 1, 32'h0,        32'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].data, vecs[i].ordy);
      checkOutput($sformatf("vec%0d", i), vecs[i].ov, vecs[i].ir, vecs[i].lvl, vecs[i].ic,
                  vecs[i].ifn, vecs[i].ra, vecs[i].rb, vecs[i].il, vecs[i].ierr,
                  vecs[i].creg, vecs[i].cimm, vecs[i].dv, vecs[i].dest);
    end

    // Flush mid-instruction drops the buffer and the same-cycle beat.
    buildMidIrmovl("fl_pre");
    applyStimulus(0, 1, 1, 32'h77665544, 1);
    checkOutput("fl_edge", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("fl_after", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);

    // Reset mid-instruction behaves the same, with in_ready low while held.
    buildMidIrmovl("rst_pre");
    applyStimulus(1, 0, 1, 32'h77665544, 1);
    checkOutput("rst_edge", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("rst_after", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);

    // irmovl straddling beats completes, then pops while the next beat is pushed.
    buildMidIrmovl("irm_pre");
    applyStimulus(0, 0, 1, 32'h77665544, 1);
    checkOutput("irm_done", 1, 1, 9, 3, 0, 15, 4, 6, 0, 1, 1, 32'h44332211, 32'h332211F4);
    applyStimulus(0, 0, 1, 32'h00000010, 1);
    checkOutput("irm_pushpop", 1, 1, 7, 5, 5, 6, 6, 6, 0, 1, 1, 32'h00001077, 32'h00107766);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
